// File: rtl/acc_pkg.sv
// Shared definitions for the adder result accumulator: FSM encodings and field widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Width of one upstream adder result {Co,S}.
    localparam int SAMP_W = 5;

    // Width of the per-frame sample counter.
    localparam int CNT_W  = 8;

endpackage

// File: rtl/adder_result_accumulator_sat_add.sv
// Unsigned W-bit adder that clamps to all-ones and flags when the true sum does not fit.
// Latency: purely combinational.
// Backpressure: none.
module sat_add #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         ovf
);

    logic [W:0] full;

    assign full = {1'b0, a} + {1'b0, b};
    assign ovf  = full[W];
    assign sum  = full[W] ? {W{1'b1}} : full[W-1:0];

endmodule

// File: rtl/adder_result_accumulator.sv
// Sums NSAMP adder results {Co,S} per frame with saturation, then presents the frame.
// Latency: out_valid rises the cycle after the final accept.
// Backpressure: in_ready drops while a frame is held; frame held until out_ready.
module adder_result_accumulator
    import acc_pkg::*;
#(
    parameter int NSAMP = 4,
    parameter int ACC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       S,
    input  logic             Co,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] Total,
    output logic             Ovf,
    output logic [CNT_W-1:0] Cnt
);

    state_t             state, state_nxt;
    logic [ACC_W-1:0]   total_q, total_nxt;
    logic               ovf_q, ovf_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt, cnt_inc;
    logic [ACC_W-1:0]   sample, sum;
    logic               add_ovf;
    logic               accept;

    assign sample  = {{(ACC_W-SAMP_W){1'b0}}, Co, S};
    assign cnt_inc = cnt_q + 8'd1;

    assign in_ready  = (state != HOLD);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid && in_ready;

    assign Total = total_q;
    assign Ovf   = ovf_q;
    assign Cnt   = cnt_q;

    sat_add #(.W(ACC_W)) u_sat_add (
        .a   (total_q),
        .b   (sample),
        .sum (sum),
        .ovf (add_ovf)
    );

    always_comb begin
        state_nxt = state;
        total_nxt = total_q;
        ovf_nxt   = ovf_q;
        cnt_nxt   = cnt_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    total_nxt = sample;
                    cnt_nxt   = 8'd1;
                    ovf_nxt   = 1'b0;
                    state_nxt = (NSAMP == 1) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    total_nxt = sum;
                    ovf_nxt   = ovf_q | add_ovf;
                    cnt_nxt   = cnt_inc;
                    if (cnt_inc == CNT_W'(NSAMP)) begin
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                // Results stay visible after the handshake until the next frame starts.
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Abort outranks any accept or handshake in the same cycle.
        if (clr) begin
            state_nxt = IDLE;
            total_nxt = '0;
            ovf_nxt   = 1'b0;
            cnt_nxt   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            total_q <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state   <= state_nxt;
            total_q <= total_nxt;
            ovf_q   <= ovf_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_adder_result_accumulator.sv
// Scoreboard bench: three instances (NSAMP 4, 16, 1), directed frames plus a random
// handshake run on the default instance; a monitor checks every completed frame.
module tb_adder_result_accumulator;

    typedef struct {
        int         dut;
        logic [7:0] total;
        logic       ovf;
        logic [7:0] cnt;
    } exp_t;

    localparam int NS [3] = '{4, 16, 1};

    logic       clk = 1'b0;
    logic       rst;
    logic       clr_a       [3];
    logic       in_valid_a  [3];
    logic       in_ready_a  [3];
    logic [3:0] s_a         [3];
    logic       co_a        [3];
    logic       out_valid_a [3];
    logic       out_ready_a [3];
    logic [7:0] total_a     [3];
    logic       ovf_a       [3];
    logic [7:0] cnt_a       [3];

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         m_cnt [3];
    int         m_tot [3];
    logic       m_ovf [3];
    logic       rnd_mode = 1'b0;

    always #5 clk = ~clk;

    adder_result_accumulator #(.NSAMP(4), .ACC_W(8)) u_dut0 (
        .clk(clk), .rst(rst), .clr(clr_a[0]), .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]),
        .S(s_a[0]), .Co(co_a[0]), .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]),
        .Total(total_a[0]), .Ovf(ovf_a[0]), .Cnt(cnt_a[0])
    );

    adder_result_accumulator #(.NSAMP(16), .ACC_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .clr(clr_a[1]), .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]),
        .S(s_a[1]), .Co(co_a[1]), .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]),
        .Total(total_a[1]), .Ovf(ovf_a[1]), .Cnt(cnt_a[1])
    );

    adder_result_accumulator #(.NSAMP(1), .ACC_W(8)) u_dut2 (
        .clk(clk), .rst(rst), .clr(clr_a[2]), .in_valid(in_valid_a[2]), .in_ready(in_ready_a[2]),
        .S(s_a[2]), .Co(co_a[2]), .out_valid(out_valid_a[2]), .out_ready(out_ready_a[2]),
        .Total(total_a[2]), .Ovf(ovf_a[2]), .Cnt(cnt_a[2])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Present one sample to instance d, wait for acceptance, and advance the frame model.
    task automatic send(input int d, input logic [4:0] v);
        int   guard;
        int   t;
        exp_t e;
        guard         = 0;
        in_valid_a[d] = 1'b1;
        s_a[d]        = v[3:0];
        co_a[d]       = v[4];
        forever begin
            @(negedge clk);
            if (in_ready_a[d] === 1'b1) break;
            guard++;
            if (guard > 200) begin
                n_cmp++;
                n_bad++;
                $display("FAIL accept_timeout dut%0d: in_ready stuck at %b, expected 1", d, in_ready_a[d]);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid_a[d] = 1'b0;
        if (guard <= 200) begin
            if (m_cnt[d] == 0) begin
                m_tot[d] = int'(v);
                m_ovf[d] = 1'b0;
            end else begin
                t = m_tot[d] + int'(v);
                if (t > 255) begin
                    m_tot[d] = 255;
                    m_ovf[d] = 1'b1;
                end else begin
                    m_tot[d] = t;
                end
            end
            m_cnt[d]++;
            if (m_cnt[d] == NS[d]) begin
                e.dut   = d;
                e.total = 8'(m_tot[d]);
                e.ovf   = m_ovf[d];
                e.cnt   = 8'(m_cnt[d]);
                sb.push_back(e);
                m_cnt[d] = 0;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every frame handshake is compared against the oldest expected frame.
    always @(negedge clk) begin : monitor
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            if (!rst && !clr_a[d] && out_valid_a[d] && out_ready_a[d]) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_frame dut%0d: Total %0d with empty scoreboard", d, total_a[d]);
                end else begin
                    e = sb.pop_front();
                    chk("frame_dut", 32'(d), 32'(e.dut));
                    chk("frame_total", 32'(total_a[d]), 32'(e.total));
                    chk("frame_ovf", 32'(ovf_a[d]), 32'(e.ovf));
                    chk("frame_cnt", 32'(cnt_a[d]), 32'(e.cnt));
                end
            end
        end
    end

    initial begin : rnd_ready
        forever begin
            @(posedge clk);
            #1;
            if (rnd_mode) out_ready_a[0] = 1'($urandom_range(0, 1));
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int guard;
        logic [4:0] v;
        exp_t dropped;
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            clr_a[d] = 1'b0; in_valid_a[d] = 1'b0; s_a[d] = 4'd0; co_a[d] = 1'b0;
            out_ready_a[d] = 1'b1; m_cnt[d] = 0; m_tot[d] = 0; m_ovf[d] = 1'b0;
        end
        repeat (3) cycle();
        rst = 1'b0;
        cycle();

        // Reset state on every instance
        for (int d = 0; d < 3; d++) begin
            chk("rst_in_ready", 32'(in_ready_a[d]), 32'd1);
            chk("rst_out_valid", 32'(out_valid_a[d]), 32'd0);
            chk("rst_total", 32'(total_a[d]), 32'd0);
            chk("rst_cnt", 32'(cnt_a[d]), 32'd0);
            chk("rst_ovf", 32'(ovf_a[d]), 32'd0);
        end

        // Default frame 5+31+0+16 = 52, one-cycle latency
        send(0, 5'd5); send(0, 5'd31); send(0, 5'd0);
        chk("lat_before_last", 32'(out_valid_a[0]), 32'd0);
        send(0, 5'd16);
        chk("lat_after_last", 32'(out_valid_a[0]), 32'd1);
        chk("hold_in_ready", 32'(in_ready_a[0]), 32'd0);
        cycle();
        chk("post_hs_valid", 32'(out_valid_a[0]), 32'd0);
        chk("post_hs_total", 32'(total_a[0]), 32'd52);
        chk("post_hs_cnt", 32'(cnt_a[0]), 32'd4);
        chk("post_hs_in_ready", 32'(in_ready_a[0]), 32'd1);

        // Abort after two accepts; the concurrent sample 9 must be dropped
        send(0, 5'd3); send(0, 5'd7);
        chk("partial_cnt", 32'(cnt_a[0]), 32'd2);
        clr_a[0] = 1'b1; in_valid_a[0] = 1'b1; s_a[0] = 4'd9; co_a[0] = 1'b0;
        cycle();
        clr_a[0] = 1'b0; in_valid_a[0] = 1'b0; m_cnt[0] = 0;
        chk("clr_cnt", 32'(cnt_a[0]), 32'd0);
        chk("clr_total", 32'(total_a[0]), 32'd0);
        chk("clr_in_ready", 32'(in_ready_a[0]), 32'd1);
        for (int i = 0; i < 4; i++) send(0, 5'd1);
        cycle();

        // Reset while holding a frame with out_ready high: frame discarded
        out_ready_a[0] = 1'b0;
        for (int i = 0; i < 4; i++) send(0, 5'd2);
        dropped = sb.pop_back();
        chk("hold_total", 32'(total_a[0]), 32'(dropped.total));
        rst = 1'b1; out_ready_a[0] = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        chk("rst_hold_valid", 32'(out_valid_a[0]), 32'd0);
        chk("rst_hold_total", 32'(total_a[0]), 32'd0);
        chk("rst_hold_in_ready", 32'(in_ready_a[0]), 32'd1);

        // NSAMP = 1: hold stable under backpressure, no zero-bubble on exit
        out_ready_a[2] = 1'b0;
        send(2, 5'd17);
        chk("n1_valid", 32'(out_valid_a[2]), 32'd1);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("n1_hold_total", 32'(total_a[2]), 32'd17);
            chk("n1_hold_in_ready", 32'(in_ready_a[2]), 32'd0);
        end
        out_ready_a[2] = 1'b1; in_valid_a[2] = 1'b1; s_a[2] = 4'd3; co_a[2] = 1'b0;
        @(negedge clk);
        chk("n1_exit_in_ready", 32'(in_ready_a[2]), 32'd0);
        cycle();
        in_valid_a[2] = 1'b0;
        chk("n1_exit_valid", 32'(out_valid_a[2]), 32'd0);
        chk("n1_exit_total", 32'(total_a[2]), 32'd17);
        send(2, 5'd3);
        cycle();

        // NSAMP = 16: 31 per sample saturates on the 9th accept
        for (int i = 0; i < 16; i++) begin
            send(1, 5'd31);
            if (i == 7) begin
                chk("sat8_total", 32'(total_a[1]), 32'd248);
                chk("sat8_ovf", 32'(ovf_a[1]), 32'd0);
            end
            if (i == 8) begin
                chk("sat9_total", 32'(total_a[1]), 32'd255);
                chk("sat9_ovf", 32'(ovf_a[1]), 32'd1);
            end
        end
        cycle();

        // Random gaps and random out_ready over 1000 frames on the default instance
        rnd_mode = 1'b1;
        for (int f = 0; f < 1000 * 4; f++) begin
            repeat ($urandom_range(0, 2)) cycle();
            v = 5'($urandom_range(0, 31));
            send(0, v);
        end
        rnd_mode = 1'b0;
        out_ready_a[0] = 1'b1;
        guard = 0;
        while (sb.size() != 0 && guard < 50) begin
            cycle();
            guard++;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
